dsp16_acc_requant: RTL

- Consumer end of the 16-lane fixed-point multiplier interface.
- Takes the packed 16 x 11-bit product vector and reduces the 16 lanes per beat through a 2-stage pipelined adder tree.
- Accumulates a dot product over a multi-beat group ended by in_last.
- Requantizes the group result back to a signed 8-bit value and holds it behind a valid/ready handshake.

---
 rtl/dsp16_acc_requant.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dsp16_acc_requant.sv
// 16-lane product reduction, group dot-product accumulate, requantize to 8 bits.
// Build option: DSP_ACC_SAT_EN selects a saturating accumulator with sticky ovf.
module dsp16_acc_requant #(
    parameter int LANE_W = 11,
    parameter int LANES  = 16,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANE_W*LANES-1:0] in_data,
    input  logic                    in_last,
    input  logic [1:0]              fixpoint_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    ovf,
    output logic [7:0]              beat_cnt
);

    localparam int GRP = 4;
    localparam int GL  = LANES / GRP;
    localparam int P_W = LANE_W + 2;
    localparam int S_W = LANE_W + 4;

    localparam logic signed [ACC_W:0] QMAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] QMIN = ~QMAX;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t state, state_n;

    logic accept;
    logic hs;

    logic signed [P_W-1:0] part_d [GRP];
    logic signed [P_W-1:0] s1_part [GRP];
    logic                  s1_valid;
    logic                  s1_last;

    logic signed [S_W-1:0] s2_sum;
    logic                  s2_valid;
    logic                  s2_last;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_n;
    logic                    sh4_q;

    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] q;
    logic [OUT_W-1:0]      q_sat;

    assign accept = in_valid & in_ready;
    assign hs     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_n;
        end
    end

    // DRAIN ends when the last beat leaves S2 and the result is loaded
    always_comb begin
        state_n = state;
        unique case (state)
            ACCUM:   if (accept && in_last) state_n = DRAIN;
            DRAIN:   if (s2_valid && s2_last) state_n = OUT;
            OUT:     if (out_ready) state_n = ACCUM;
            default: state_n = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == OUT);
    end

    always_comb begin
        for (int g = 0; g < GRP; g++) begin
            part_d[g] = '0;
            for (int l = 0; l < GL; l++) begin
                part_d[g] = part_d[g]
                    + P_W'(signed'(in_data[LANE_W*(GL*g+l) +: LANE_W]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < GRP; g++) s1_part[g] <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_sum   <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                for (int g = 0; g < GRP; g++) s1_part[g] <= part_d[g];
                s1_last <= in_last;
            end
            s2_valid <= s1_valid;
            s2_last  <= s1_valid & s1_last;
            s2_sum   <= S_W'(s1_part[0]) + S_W'(s1_part[1])
                      + S_W'(s1_part[2]) + S_W'(s1_part[3]);
        end
    end

`ifdef DSP_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] AMIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_w;
    logic                  clamp;
    logic                  ovf_acc;
    logic                  ovf_q;

    always_comb begin
        sum_w = {acc[ACC_W-1], acc} + (ACC_W+1)'(s2_sum);
        clamp = sum_w[ACC_W] != sum_w[ACC_W-1];
        acc_n = sum_w[ACC_W-1:0];
        if (clamp) acc_n = sum_w[ACC_W] ? AMIN : AMAX;
    end

    // sticky within the group, handed to the result on the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_acc <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (s2_valid && s2_last) begin
                ovf_q   <= ovf_acc | clamp;
                ovf_acc <= 1'b0;
            end else begin
                if (s2_valid) ovf_acc <= ovf_acc | clamp;
                if (hs) ovf_q <= 1'b0;
            end
        end
    end

    assign ovf = ovf_q;
`else
    always_comb acc_n = acc + ACC_W'(s2_sum);

    assign ovf = 1'b0;
`endif

    always_comb begin
        rnd   = {acc_n[ACC_W-1], acc_n} + (ACC_W+1)'(sh4_q ? 8 : 2);
        q     = sh4_q ? (rnd >>> 4) : (rnd >>> 2);
        q_sat = q[OUT_W-1:0];
        if (q > QMAX) q_sat = QMAX[OUT_W-1:0];
        else if (q < QMIN) q_sat = QMIN[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            out_data <= '0;
            beat_cnt <= '0;
            sh4_q    <= 1'b0;
        end else begin
            if (s2_valid) begin
                if (s2_last) begin
                    acc      <= '0;
                    out_data <= q_sat;
                end else begin
                    acc <= acc_n;
                end
            end
            if (accept) begin
                beat_cnt <= beat_cnt + 8'd1;
                if (beat_cnt == 8'd0) sh4_q <= (fixpoint_op == 2'd0);
            end else if (hs) begin
                beat_cnt <= '0;
            end
        end
    end

endmodule
